// File: rtl/password_pkg.sv
// Shared types and bit-counting helpers for the password attempt checker.
// Helpers are width-generic up to PW_MAX_W; callers truncate to their own width.
package password_pkg;

    typedef enum logic [1:0] {IDLE, CHECK, OPEN, LOCKED} pw_state_t;

    localparam int PW_MAX_W = 64;

    function automatic int popcount(input logic [PW_MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < PW_MAX_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // Bit i set iff i < count.
    function automatic logic [PW_MAX_W-1:0] thermometer(input int count);
        logic [PW_MAX_W-1:0] t;
        t = '0;
        for (int i = 0; i < PW_MAX_W; i++) begin
            t[i] = (i < count);
        end
        return t;
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter: load sets CYCLES-1, then it counts to zero and holds.
// expired is high whenever the count sits at zero.
module lockout_timer #(
    parameter int CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);
    localparam int TW = $clog2(CYCLES);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = TW'(CYCLES - 1);
        end else if (count_q != '0) begin
            count_d = count_q - TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/password_attempt_checker.sv
// Password verifier: captures an entry on an enter rising edge, scores it next cycle,
// and enforces a timed lockout after MAX_TRIES consecutive wrong entries.
module password_attempt_checker
    import password_pkg::*;
#(
    parameter int WIDTH          = 10,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 100_000_000
) (
    input  logic                           clk,
    input  logic                           resetBit,
    input  logic                           enter,
    input  logic [WIDTH-1:0]               password,
    input  logic [WIDTH-1:0]               user_input,
    output logic                           success,
    output logic                           fail_pulse,
    output logic                           result_valid,
    output logic                           locked,
    output logic [$clog2(MAX_TRIES+1)-1:0] attempts_left,
    output logic [$clog2(WIDTH+1)-1:0]     correct_count,
    output logic [WIDTH-1:0]               number_correct
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = $clog2(MAX_TRIES + 1);
    localparam logic [AW-1:0] TRIES = AW'(MAX_TRIES);

    pw_state_t        state_q, state_d;
    logic             enter_q;
    logic [WIDTH-1:0] cap_in_q, cap_in_d, cap_pw_q, cap_pw_d;
    logic             success_q, success_d, fail_q, fail_d, valid_q, valid_d;
    logic             locked_q, locked_d;
    logic [AW-1:0]    attempts_q, attempts_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] therm_q, therm_d;
    logic [WIDTH-1:0] match;
    logic [CW-1:0]    match_cnt;
    logic             enter_rise, timer_load, timer_expired;

    lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst     (resetBit),
        .load    (timer_load),
        .expired (timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        cap_in_d   = cap_in_q;
        cap_pw_d   = cap_pw_q;
        success_d  = success_q;
        fail_d     = 1'b0;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        attempts_d = attempts_q;
        count_d    = count_q;
        therm_d    = therm_q;
        timer_load = 1'b0;
        enter_rise = enter & ~enter_q;
        match      = ~(cap_in_q ^ cap_pw_q);
        match_cnt  = CW'(popcount(PW_MAX_W'(match)));

        unique case (state_q)
            IDLE: begin
                if (enter_rise) begin
                    cap_in_d = user_input;
                    cap_pw_d = password;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                count_d = match_cnt;
                therm_d = WIDTH'(thermometer(int'(match_cnt)));
                valid_d = 1'b1;
                if (&match) begin
                    state_d    = OPEN;
                    success_d  = 1'b1;
                    attempts_d = TRIES;
                end else begin
                    fail_d = 1'b1;
                    // Saturating decrement: the last try (or a corrupted zero) locks out.
                    if (attempts_q > AW'(1)) begin
                        attempts_d = attempts_q - AW'(1);
                        state_d    = IDLE;
                    end else begin
                        attempts_d = '0;
                        state_d    = LOCKED;
                        locked_d   = 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            OPEN: begin
                if (enter_rise) begin
                    state_d   = IDLE;
                    success_d = 1'b0;
                    count_d   = '0;
                    therm_d   = '0;
                end
            end
            LOCKED: begin
                if (timer_expired) begin
                    state_d    = IDLE;
                    locked_d   = 1'b0;
                    attempts_d = TRIES;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetBit) begin
            state_q    <= IDLE;
            enter_q    <= 1'b0;
            cap_in_q   <= '0;
            cap_pw_q   <= '0;
            success_q  <= 1'b0;
            fail_q     <= 1'b0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            attempts_q <= TRIES;
            count_q    <= '0;
            therm_q    <= '0;
        end else begin
            state_q    <= state_d;
            enter_q    <= enter;
            cap_in_q   <= cap_in_d;
            cap_pw_q   <= cap_pw_d;
            success_q  <= success_d;
            fail_q     <= fail_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            attempts_q <= attempts_d;
            count_q    <= count_d;
            therm_q    <= therm_d;
        end
    end

    assign success        = success_q;
    assign fail_pulse     = fail_q;
    assign result_valid   = valid_q;
    assign locked         = locked_q;
    assign attempts_left  = attempts_q;
    assign correct_count  = count_q;
    assign number_correct = therm_q;

endmodule

// File: tb/tb_password_attempt_checker.sv
// Bench for password_attempt_checker: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of entries, tries and lockout time.
module tb_password_attempt_checker;
    localparam int W  = 10;
    localparam int MT = 3;
    localparam int LC = 20;

    logic clk = 1'b0;
    logic resetBit = 1'b1;
    logic enter = 1'b0;
    logic [W-1:0] password = '0, user_input = '0;
    logic success, fail_pulse, result_valid, locked;
    logic [1:0] attempts_left;
    logic [3:0] correct_count;
    logic [W-1:0] number_correct;

    int compares = 0;
    int fails = 0;

    always #5 clk = ~clk;

    password_attempt_checker #(.WIDTH(W), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)) dut (
        .clk            (clk),
        .resetBit       (resetBit),
        .enter          (enter),
        .password       (password),
        .user_input     (user_input),
        .success        (success),
        .fail_pulse     (fail_pulse),
        .result_valid   (result_valid),
        .locked         (locked),
        .attempts_left  (attempts_left),
        .correct_count  (correct_count),
        .number_correct (number_correct)
    );

    // Model: an accepted entry is scored on the following edge; lockout is a
    // count of remaining locked cycles; success is an "open" flag.
    bit       m_prev = 0, m_pend = 0, m_open = 0, m_valid = 0, m_fail = 0;
    int       m_lock = 0, m_tries = MT, m_cnt = 0;
    logic [W-1:0] m_in = '0, m_pw = '0;
    logic [W-1:0] exp_therm;
    logic [19:0]  obs, exp;

    always @(posedge clk) begin : model
        bit rise, pend, open, valid, fail;
        int lock, tries, cnt;
        logic [W-1:0] in_c, pw_c;
        pend = m_pend; open = m_open; lock = m_lock; tries = m_tries; cnt = m_cnt;
        in_c = m_in; pw_c = m_pw;
        rise = enter && !m_prev;
        valid = 0; fail = 0;
        if (resetBit) begin
            pend = 0; open = 0; lock = 0; tries = MT; cnt = 0;
        end else if (pend) begin
            cnt = $countones(~(in_c ^ pw_c));
            valid = 1; pend = 0;
            if (cnt == W) begin
                open = 1; tries = MT;
            end else begin
                fail = 1; tries = tries - 1;
                if (tries == 0) lock = LC;
            end
        end else if (lock > 0) begin
            lock = lock - 1;
            if (lock == 0) tries = MT;
        end else if (open) begin
            if (rise) begin open = 0; cnt = 0; end
        end else if (rise) begin
            pend = 1; in_c = user_input; pw_c = password;
        end
        m_prev  <= resetBit ? 1'b0 : enter;
        m_pend  <= pend;  m_open  <= open;  m_lock <= lock;
        m_tries <= tries; m_cnt   <= cnt;   m_in   <= in_c; m_pw <= pw_c;
        m_valid <= valid; m_fail  <= fail;
    end

    always_comb begin
        exp_therm = '0;
        for (int i = 0; i < W; i++) exp_therm[i] = (i < m_cnt);
    end

    assign exp = {m_open, m_fail, m_valid, (m_lock > 0), 2'(m_tries), 4'(m_cnt), exp_therm};
    assign obs = {success, fail_pulse, result_valid, locked, attempts_left, correct_count, number_correct};

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        resetBit = 1; enter = 0;
        tick(2);
        compares++;
        if (obs !== 20'({4'b0000, 2'd3, 4'd0, 10'd0})) begin
            fails++; $display("FAIL reset_values: got %h expected %h", obs, {4'b0000, 2'd3, 4'd0, 10'd0});
        end
        compares++;
        if (obs !== exp) begin fails++; $display("FAIL reset_model: got %h expected %h", obs, exp); end
        resetBit = 0;
        tick(1);
    endtask

    task automatic test_correct;
        password = 10'h2A5; user_input = 10'h2A5; enter = 1;
        tick(2);
        compares++;
        if ({success, result_valid, attempts_left, correct_count, number_correct} !== {1'b1, 1'b1, 2'd3, 4'd10, 10'h3FF}) begin
            fails++; $display("FAIL correct_entry: got %b %b %0d %0d %h expected 1 1 3 10 3ff",
                              success, result_valid, attempts_left, correct_count, number_correct);
        end
        compares++;
        if (obs !== exp) begin fails++; $display("FAIL correct_model: got %h expected %h", obs, exp); end
        enter = 0; password = 10'h000;
        tick(2);
        compares++;
        if ({success, result_valid} !== 2'b10) begin
            fails++; $display("FAIL open_hold: got success=%b valid=%b expected 1 0", success, result_valid);
        end
        enter = 1;
        tick(1);
        compares++;
        if ({success, correct_count, number_correct} !== {1'b0, 4'd0, 10'd0}) begin
            fails++; $display("FAIL relock: got %b %0d %h expected 0 0 000", success, correct_count, number_correct);
        end
        enter = 0;
        tick(1);
    endtask

    task automatic test_partial;
        password = 10'h2A5; user_input = 10'h2A4; enter = 1;
        tick(2);
        compares++;
        if ({fail_pulse, result_valid, success, attempts_left, correct_count, number_correct} !==
            {1'b1, 1'b1, 1'b0, 2'd2, 4'd9, 10'h1FF}) begin
            fails++; $display("FAIL partial: got %b %b %b %0d %0d %h expected 1 1 0 2 9 1ff",
                              fail_pulse, result_valid, success, attempts_left, correct_count, number_correct);
        end
        enter = 0;
        tick(1);
        compares++;
        if ({fail_pulse, result_valid} !== 2'b00) begin
            fails++; $display("FAIL fail_one_cycle: got fail=%b valid=%b expected 0 0", fail_pulse, result_valid);
        end
        compares++;
        if (obs !== exp) begin fails++; $display("FAIL partial_model: got %h expected %h", obs, exp); end
    endtask

    task automatic test_lockout;
        int nlock, nvalid;
        resetBit = 1; tick(1); resetBit = 0; enter = 0; tick(1);
        for (int k = 0; k < 3; k++) begin
            password = 10'h2A5; user_input = 10'h15A; enter = 1;
            tick(2);
            compares++;
            if ({fail_pulse, attempts_left, correct_count, locked} !== {1'b1, 2'(2 - k), 4'd0, (k == 2)}) begin
                fails++; $display("FAIL wrong_entry_%0d: got fail=%b left=%0d cnt=%0d locked=%b expected 1 %0d 0 %0d",
                                  k, fail_pulse, attempts_left, correct_count, locked, 2 - k, k == 2);
            end
            enter = 0;
            if (k < 2) tick(1);
        end
        nlock = 1; nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            enter = 1'($urandom_range(0, 1));
            user_input = 10'h2A5;
            tick(1);
            compares++;
            if (obs !== exp) begin fails++; $display("FAIL lockout_model c%0d: got %h expected %h", c, obs, exp); end
            if (result_valid) nvalid++;
            if (!locked) break;
            nlock++;
        end
        compares++;
        if (nlock !== LC) begin fails++; $display("FAIL lock_length: got %0d expected %0d", nlock, LC); end
        compares++;
        if (nvalid !== 0) begin fails++; $display("FAIL lock_ignores_enter: got %0d expected 0", nvalid); end
        compares++;
        if (attempts_left !== 2'd3) begin fails++; $display("FAIL unlock_tries: got %0d expected 3", attempts_left); end
        enter = 0;
        tick(2);
    endtask

    task automatic test_held_enter;
        int nvalid;
        nvalid = 0;
        password = 10'h3C3; user_input = 10'h3C2; enter = 1;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            compares++;
            if (obs !== exp) begin fails++; $display("FAIL held_model c%0d: got %h expected %h", c, obs, exp); end
            if (result_valid) nvalid++;
        end
        compares++;
        if (nvalid !== 1) begin fails++; $display("FAIL held_enter: got %0d results expected 1", nvalid); end
        enter = 0;
        tick(1);
    endtask

    task automatic test_back_to_back;
        for (int c = 0; c < 16; c++) begin
            enter = ~enter;
            password = 10'($urandom);
            user_input = (c % 5 == 0) ? password : password ^ 10'(1 << (c % W));
            tick(1);
            compares++;
            if (obs !== exp) begin fails++; $display("FAIL b2b_model c%0d: got %h expected %h", c, obs, exp); end
        end
        enter = 0;
        tick(2);
    endtask

    task automatic test_reset_mid_lockout;
        resetBit = 1; tick(1); resetBit = 0; tick(1);
        password = 10'h0F0; user_input = 10'h00F;
        for (int k = 0; k < 3; k++) begin
            enter = 1; tick(2); enter = 0; tick(1);
        end
        tick(5);
        compares++;
        if (locked !== 1'b1) begin fails++; $display("FAIL mid_lock_precheck: got locked=%b expected 1", locked); end
        resetBit = 1; enter = 1;
        tick(1);
        compares++;
        if (obs !== 20'({4'b0000, 2'd3, 4'd0, 10'd0})) begin
            fails++; $display("FAIL reset_mid_lockout: got %h expected %h", obs, {4'b0000, 2'd3, 4'd0, 10'd0});
        end
        // Enter stays high as reset releases: exactly one edge is seen.
        password = 10'h155; user_input = 10'h155;
        resetBit = 0;
        tick(2);
        compares++;
        if ({result_valid, success, correct_count} !== {1'b1, 1'b1, 4'd10}) begin
            fails++; $display("FAIL enter_at_reset_release: got valid=%b success=%b cnt=%0d expected 1 1 10",
                              result_valid, success, correct_count);
        end
        enter = 0;
        tick(1);
    endtask

    task automatic test_random;
        for (int c = 0; c < 800; c++) begin
            resetBit = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 2) == 0) enter = ~enter;
            password = 10'($urandom);
            user_input = ($urandom_range(0, 3) == 0) ? password : password ^ 10'($urandom_range(1, 1023));
            tick(1);
            compares++;
            if (obs !== exp) begin fails++; $display("FAIL random_model c%0d: got %h expected %h", c, obs, exp); end
        end
        resetBit = 0; enter = 0;
        tick(1);
    endtask

    initial begin
        tick(1);
        test_reset();
        test_correct();
        test_partial();
        test_lockout();
        test_held_enter();
        test_back_to_back();
        test_reset_mid_lockout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
